// File: rtl/fft_peak_reader.sv
// Reads back FFT result bins after the core finishes, streams |X[k]|^2 per bin
// and keeps the largest-magnitude bin of the most recent complete sweep.
module fft_peak_reader #(
    parameter int bit_width = 16,
    parameter int M         = 9,
    parameter int N         = 512,
    parameter int MIN_BIN   = 1,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    output logic [M-1:0]           fft_adr,
    input  logic [2*bit_width-1:0] fft_wd,
    output logic                   bin_valid,
    output logic [M-1:0]           bin_idx,
    output logic [2*bit_width:0]   bin_mag,
    output logic                   peak_valid,
    output logic [M-1:0]           peak_idx,
    output logic [2*bit_width:0]   peak_mag,
    output logic                   frame_done,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam logic [M-1:0] FIRST_BIN = M'(MIN_BIN);
    localparam logic [M-1:0] LAST_BIN  = M'(N / 2 - 1);
    localparam int           DW        = $clog2(RD_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              done_q;
    logic              done_rise;
    logic              drain_last;
    logic              abort;
    logic [M-1:0]      adr_q;
    logic [DW-1:0]     drain_cnt;
    logic              v_sr   [RD_LAT];
    logic [M-1:0]      idx_sr [RD_LAT];

    logic signed [bit_width-1:0]   re;
    logic signed [bit_width-1:0]   im;
    logic [2*bit_width-1:0]        re_x;
    logic [2*bit_width-1:0]        im_x;
    logic [2*bit_width-1:0]        re_sq;
    logic [2*bit_width-1:0]        im_sq;
    logic [2*bit_width:0]          mag;

    assign done_rise  = fft_done & ~done_q;
    assign drain_last = (drain_cnt == DW'(RD_LAT));
    assign abort      = ~fft_done & ((state == SWEEP) | (state == DRAIN));

    // Full-width squares: (-2^(w-1))^2 needs all 2w bits, so sign-extend before multiplying.
    assign re    = fft_wd[2*bit_width-1:bit_width];
    assign im    = fft_wd[bit_width-1:0];
    assign re_x  = {{bit_width{re[bit_width-1]}}, re};
    assign im_x  = {{bit_width{im[bit_width-1]}}, im};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign mag   = {1'b0, re_sq} + {1'b0, im_sq};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (done_rise) state_nxt = SWEEP;
            SWEEP: begin
                if (!fft_done)              state_nxt = IDLE;
                else if (adr_q == LAST_BIN) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!fft_done)       state_nxt = IDLE;
                else if (drain_last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fft_adr    = (state == SWEEP) ? adr_q : '0;
        busy       = (state == SWEEP) | (state == DRAIN);
        frame_done = (state == DRAIN) & drain_last & fft_done;
        state_dbg  = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q     <= 1'b0;
            adr_q      <= FIRST_BIN;
            drain_cnt  <= '0;
            bin_valid  <= 1'b0;
            bin_idx    <= '0;
            bin_mag    <= '0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                v_sr[i]   <= 1'b0;
                idx_sr[i] <= '0;
            end
        end else begin
            done_q    <= fft_done;
            adr_q     <= (state == SWEEP) ? adr_q + M'(1) : FIRST_BIN;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;

            // Index/valid travel alongside the RAM read; an abort flushes them.
            for (int i = RD_LAT - 1; i > 0; i--) begin
                v_sr[i]   <= v_sr[i-1] & ~abort;
                idx_sr[i] <= idx_sr[i-1];
            end
            v_sr[0]   <= (state == SWEEP) & ~abort;
            idx_sr[0] <= fft_adr;
            bin_valid <= v_sr[RD_LAT-1] & ~abort;
            bin_idx   <= idx_sr[RD_LAT-1];
            bin_mag   <= mag;

            if ((state_nxt == SWEEP) && (state != SWEEP)) begin
                peak_valid <= 1'b0;
                peak_idx   <= '0;
                peak_mag   <= '0;
            end else begin
                // Strictly greater keeps the lowest index on ties.
                if (bin_valid && ((bin_idx == FIRST_BIN) || (bin_mag > peak_mag))) begin
                    peak_idx <= bin_idx;
                    peak_mag <= bin_mag;
                end
                if (frame_done) peak_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_reader.sv
// Directed bench for fft_peak_reader: a registered-read RAM model feeds bins,
// each task checks one behaviour against hand-computed values.
module tb_fft_peak_reader;

    localparam int BW = 16;
    localparam int M  = 9;
    localparam int N  = 512;

    logic            clk = 1'b0;
    logic            reset;
    logic            fft_done;
    logic [M-1:0]    fft_adr;
    logic [2*BW-1:0] fft_wd;
    logic            bin_valid;
    logic [M-1:0]    bin_idx;
    logic [2*BW:0]   bin_mag;
    logic            peak_valid;
    logic [M-1:0]    peak_idx;
    logic [2*BW:0]   peak_mag;
    logic            frame_done;
    logic            busy;
    logic [1:0]      state_dbg;

    logic [2*BW-1:0] mem [0:N-1];
    int              tests_run = 0;
    int              tests_failed = 0;
    int              fd_count = 0;
    int              sweep_count = 0;
    logic            busy_d = 1'b0;
    logic [M-1:0]    got_idx[$];
    logic [2*BW:0]   got_mag[$];
    logic [M-1:0]    exp_q[$];

    fft_peak_reader dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .fft_adr(fft_adr), .fft_wd(fft_wd),
        .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_mag(bin_mag),
        .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_mag(peak_mag),
        .frame_done(frame_done), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / RAM model / stream recorder
    always #5 clk = ~clk;

    always @(posedge clk) fft_wd <= mem[fft_adr];

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (busy === 1'b1 && busy_d !== 1'b1) sweep_count++;
        busy_d = busy;
        if (bin_valid === 1'b1) begin
            got_idx.push_back(bin_idx);
            got_mag.push_back(bin_mag);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic signed [BW-1:0] re, input logic signed [BW-1:0] im);
        for (int i = 0; i < N; i++) mem[i] = {re, im};
    endtask

    task automatic set_bin(input int k, input logic signed [BW-1:0] re, input logic signed [BW-1:0] im);
        mem[k] = {re, im};
    endtask

    task automatic start_sweep();
        fft_done = 1'b0;
        tick();
        tick();
        got_idx.delete();
        got_mag.delete();
        fft_done = 1'b1;
    endtask

    task automatic wait_frame(input int budget, input string name);
        int  start;
        bit  seen;
        start = fd_count;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (fd_count > start) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        fft_done = 1'b0;
        fill(0, 0);
        repeat (3) tick();
        tests_run++; if (bin_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_bin_valid: got %b want 0", bin_valid); end
        tests_run++; if (bin_idx !== '0) begin tests_failed++; $display("FAIL rst_bin_idx: got %0d want 0", bin_idx); end
        tests_run++; if (bin_mag !== '0) begin tests_failed++; $display("FAIL rst_bin_mag: got %0d want 0", bin_mag); end
        tests_run++; if (peak_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_peak_valid: got %b want 0", peak_valid); end
        tests_run++; if (peak_idx !== '0) begin tests_failed++; $display("FAIL rst_peak_idx: got %0d want 0", peak_idx); end
        tests_run++; if (peak_mag !== '0) begin tests_failed++; $display("FAIL rst_peak_mag: got %0d want 0", peak_mag); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests_run++; if (fft_adr !== '0) begin tests_failed++; $display("FAIL rst_fft_adr: got %0d want 0", fft_adr); end
        tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_tone();
        int fd0;
        fill(1, 1);
        set_bin(37, 1000, -500);
        fd0 = fd_count;
        start_sweep();
        wait_frame(400, "tone_frame");
        repeat (5) tick();
        tests_run++; if (peak_valid !== 1'b1) begin tests_failed++; $display("FAIL tone_peak_valid: got %b want 1", peak_valid); end
        tests_run++; if (peak_idx !== 9'd37) begin tests_failed++; $display("FAIL tone_peak_idx: got %0d want 37", peak_idx); end
        tests_run++; if (peak_mag !== 33'd1250000) begin tests_failed++; $display("FAIL tone_peak_mag: got %0d want 1250000", peak_mag); end
        tests_run++; if (fd_count - fd0 != 1) begin tests_failed++; $display("FAIL tone_frame_count: got %0d want 1", fd_count - fd0); end
        tests_run++; if (got_idx.size() != 255) begin tests_failed++; $display("FAIL tone_bin_count: got %0d want 255", got_idx.size()); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL tone_busy: got %b want 0", busy); end
        fft_done = 1'b0;
        repeat (3) tick();
        tests_run++; if (state_dbg !== 2'd3) begin tests_failed++; $display("FAIL tone_fall_state: got %0d want 3", state_dbg); end
        tests_run++; if (peak_valid !== 1'b1 || peak_idx !== 9'd37) begin tests_failed++; $display("FAIL tone_fall_hold: got valid %b idx %0d want 1/37", peak_valid, peak_idx); end
    endtask

    task automatic test_stream();
        logic signed [BW-1:0] a;
        logic [M-1:0]         e;
        logic [2*BW:0]        em;
        for (int k = 0; k < N; k++) begin
            a = 16'(k);
            set_bin(k, a, -a);
        end
        exp_q.delete();
        for (int k = 1; k < 256; k++) exp_q.push_back(9'(k));
        fft_done = 1'b0;
        tick();
        tick();
        fft_done = 1'b1;
        tick();
        tests_run++; if (fft_adr !== 9'd1) begin tests_failed++; $display("FAIL lat_adr_c1: got %0d want 1", fft_adr); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL lat_busy_c1: got %b want 1", busy); end
        tick();
        tests_run++; if (bin_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_valid_c2: got %b want 0", bin_valid); end
        for (int c = 3; c <= 257; c++) begin
            tick();
            tests_run++;
            if (bin_valid !== 1'b1) begin
                tests_failed++; $display("FAIL stream_valid c%0d: got %b want 1", c, bin_valid);
            end else if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                em = 33'(2 * int'(e) * int'(e));
                tests_run++; if (bin_idx !== e) begin tests_failed++; $display("FAIL stream_idx c%0d: got %0d want %0d", c, bin_idx, e); end
                tests_run++; if (bin_mag !== em) begin tests_failed++; $display("FAIL stream_mag c%0d: got %0d want %0d", c, bin_mag, em); end
            end
            if (c == 256) begin
                tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL stream_fd_early: got %b want 0", frame_done); end
            end
            if (c == 257) begin
                tests_run++; if (frame_done !== 1'b1) begin tests_failed++; $display("FAIL stream_fd_c257: got %b want 1", frame_done); end
            end
        end
        tick();
        tests_run++; if (bin_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_valid_end: got %b want 0", bin_valid); end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL stream_missing: %0d bins left want 0", exp_q.size()); end
        tests_run++; if (peak_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_peak_valid: got %b want 1", peak_valid); end
        tests_run++; if (peak_idx !== 9'd255) begin tests_failed++; $display("FAIL stream_peak_idx: got %0d want 255", peak_idx); end
        tests_run++; if (peak_mag !== 33'd130050) begin tests_failed++; $display("FAIL stream_peak_mag: got %0d want 130050", peak_mag); end
    endtask

    task automatic test_extremes();
        fill(0, 0);
        set_bin(10, -32768, -32768);
        set_bin(200, -32768, -32768);
        start_sweep();
        wait_frame(400, "ext_frame");
        tick();
        tests_run++; if (peak_idx !== 9'd10) begin tests_failed++; $display("FAIL ext_peak_idx: got %0d want 10", peak_idx); end
        tests_run++; if (peak_mag !== 33'd2147483648) begin tests_failed++; $display("FAIL ext_peak_mag: got %0d want 2147483648", peak_mag); end
        tests_run++;
        if (got_mag.size() != 255) begin
            tests_failed++; $display("FAIL ext_bin_count: got %0d want 255", got_mag.size());
        end else begin
            tests_run++; if (got_idx[199] !== 9'd200) begin tests_failed++; $display("FAIL ext_idx200: got %0d want 200", got_idx[199]); end
            tests_run++; if (got_mag[199] !== 33'd2147483648) begin tests_failed++; $display("FAIL ext_mag200: got %0d want 2147483648", got_mag[199]); end
            tests_run++; if (got_mag[10] !== 33'd0) begin tests_failed++; $display("FAIL ext_mag11: got %0d want 0", got_mag[10]); end
        end
    endtask

    task automatic test_zero_frame();
        fill(0, 0);
        start_sweep();
        wait_frame(400, "zero_frame");
        tick();
        tests_run++; if (peak_valid !== 1'b1) begin tests_failed++; $display("FAIL zero_peak_valid: got %b want 1", peak_valid); end
        tests_run++; if (peak_idx !== 9'd1) begin tests_failed++; $display("FAIL zero_peak_idx: got %0d want 1", peak_idx); end
        tests_run++; if (peak_mag !== 33'd0) begin tests_failed++; $display("FAIL zero_peak_mag: got %0d want 0", peak_mag); end
    endtask

    task automatic test_abort();
        int fd0;
        bit hit;
        fill(1, 1);
        fd0 = fd_count;
        hit = 1'b0;
        start_sweep();
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            if (fft_adr === 9'd100) hit = 1'b1;
        end
        tests_run++; if (!hit) begin tests_failed++; $display("FAIL abort_reach_100: got no address 100 want address 100"); end
        fft_done = 1'b0;
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b want 0", busy); end
        tests_run++; if (bin_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_bin_valid: got %b want 0", bin_valid); end
        tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL abort_state: got %0d want 0", state_dbg); end
        repeat (5) tick();
        tests_run++; if (peak_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_peak_valid: got %b want 0", peak_valid); end
        tests_run++; if (fd_count != fd0) begin tests_failed++; $display("FAIL abort_frame_done: got %0d pulses want 0", fd_count - fd0); end
    endtask

    task automatic test_stuck_done();
        int sc0;
        int fd0;
        sc0 = sweep_count;
        fd0 = fd_count;
        fft_done = 1'b1;
        repeat (2000) tick();
        tests_run++; if (sweep_count - sc0 != 1) begin tests_failed++; $display("FAIL stuck_sweeps: got %0d want 1", sweep_count - sc0); end
        tests_run++; if (fd_count - fd0 != 1) begin tests_failed++; $display("FAIL stuck_frames: got %0d want 1", fd_count - fd0); end
        tests_run++; if (peak_valid !== 1'b1 || peak_mag !== 33'd2) begin tests_failed++; $display("FAIL stuck_peak: got valid %b mag %0d want 1/2", peak_valid, peak_mag); end
        fft_done = 1'b0;
        tick();
        tick();
        fft_done = 1'b1;
        tick();
        tests_run++; if (peak_valid !== 1'b0) begin tests_failed++; $display("FAIL retrig_peak_valid: got %b want 0", peak_valid); end
        tests_run++; if (peak_mag !== 33'd0 || peak_idx !== 9'd0) begin tests_failed++; $display("FAIL retrig_peak_clear: got idx %0d mag %0d want 0/0", peak_idx, peak_mag); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL retrig_busy: got %b want 1", busy); end
        wait_frame(400, "retrig_frame");
        tests_run++; if (sweep_count - sc0 != 2) begin tests_failed++; $display("FAIL retrig_sweeps: got %0d want 2", sweep_count - sc0); end
    endtask

    task automatic test_reset_drain();
        bit hit;
        hit = 1'b0;
        fill(1, 1);
        start_sweep();
        for (int i = 0; i < 400 && !hit; i++) begin
            tick();
            if (state_dbg === 2'd2) hit = 1'b1;
        end
        tests_run++; if (!hit) begin tests_failed++; $display("FAIL rd_reach_drain: got no DRAIN want DRAIN"); end
        reset = 1'b1;
        tick();
        tests_run++; if (bin_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin tests_failed++; $display("FAIL rd_ctrl: got valid %b busy %b fd %b want 0/0/0", bin_valid, busy, frame_done); end
        tests_run++; if (peak_valid !== 1'b0 || peak_idx !== '0 || peak_mag !== '0) begin tests_failed++; $display("FAIL rd_peak: got %b/%0d/%0d want 0/0/0", peak_valid, peak_idx, peak_mag); end
        tests_run++; if (bin_idx !== '0 || bin_mag !== '0 || fft_adr !== '0) begin tests_failed++; $display("FAIL rd_data: got %0d/%0d/%0d want 0/0/0", bin_idx, bin_mag, fft_adr); end
        fft_done = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        set_bin(77, 100, 100);
        start_sweep();
        wait_frame(400, "rd_frame");
        tick();
        tests_run++; if (peak_idx !== 9'd77) begin tests_failed++; $display("FAIL rd_peak_idx: got %0d want 77", peak_idx); end
        tests_run++; if (peak_mag !== 33'd20000) begin tests_failed++; $display("FAIL rd_peak_mag: got %0d want 20000", peak_mag); end
        tests_run++; if (got_idx.size() != 255) begin tests_failed++; $display("FAIL rd_bin_count: got %0d want 255", got_idx.size()); end
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_stream();
        test_extremes();
        test_zero_frame();
        test_abort();
        test_stuck_done();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
